// File: rtl/scalar_operand_fetch.sv
// Operand-fetch stage ahead of the scalar ALU: resolves SGPR, inline-constant and literal
// sources for one SOP2 instruction and holds them under a valid/ready handshake.
module scalar_operand_fetch #(
    parameter int LIT_W = 32,
    parameter int OP_W  = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_ssrc0,
    input  logic [7:0]       in_ssrc1,
    input  logic [7:0]       in_sdst,
    input  logic [7:0]       in_opcode,
    input  logic             in_en_64,
    output logic [7:0]       rf_s0,
    output logic [7:0]       rf_s1,
    input  logic [OP_W-1:0]  rf_r0,
    input  logic [OP_W-1:0]  rf_r1,
    input  logic             lit_valid,
    output logic             lit_ready,
    input  logic [LIT_W-1:0] lit_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  out_op0,
    output logic [OP_W-1:0]  out_op1,
    output logic [7:0]       out_sdst,
    output logic [7:0]       out_opcode,
    output logic             out_en_64,
    output logic             out_illegal,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer on either in_* or out_* happens on a rising edge where valid and
    // ready are both 1; lit_* transfers when lit_valid and lit_ready are both 1.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LIT_WAIT = 2'd1,
        HOLD     = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] val;
        logic            ill;
        logic            lit;
    } src_t;

    function automatic src_t decode(input logic [7:0] code, input logic [OP_W-1:0] rf);
        src_t s;
        s.val = '0;
        s.ill = 1'b0;
        s.lit = 1'b0;
        case (code) inside
            [8'h00:8'h7F], [8'hFB:8'hFD]: s.val = rf;
            8'h80:                        s.val = '0;
            [8'h81:8'hC0]:                s.val = OP_W'(code) - OP_W'(128);
            [8'hC1:8'hD0]:                s.val = OP_W'(192) - OP_W'(code);
            8'hF0:                        s.val = OP_W'(32'h3F00_0000);
            8'hF1:                        s.val = OP_W'(32'hBF00_0000);
            8'hF2:                        s.val = OP_W'(32'h3F80_0000);
            8'hF3:                        s.val = OP_W'(32'hBF80_0000);
            8'hF4:                        s.val = OP_W'(32'h4000_0000);
            8'hF5:                        s.val = OP_W'(32'hC000_0000);
            8'hF6:                        s.val = OP_W'(32'h4080_0000);
            8'hF7:                        s.val = OP_W'(32'hC080_0000);
            8'hFF:                        s.lit = 1'b1;
            default:                      s.ill = 1'b1;
        endcase
        return s;
    endfunction

    state_t          state_q, state_d;
    logic [OP_W-1:0] op0_q, op0_d, op1_q, op1_d;
    logic            lit0_q, lit0_d, lit1_q, lit1_d;
    logic            ill_q, ill_d, en64_q, en64_d;
    logic [7:0]      sdst_q, sdst_d, opc_q, opc_d;
    logic            accept;
    src_t            dec0, dec1;

    assign rf_s0 = in_ssrc0;
    assign rf_s1 = in_ssrc1;
    assign dec0  = decode(in_ssrc0, rf_r0);
    assign dec1  = decode(in_ssrc1, rf_r1);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        lit_ready = 1'b0;
        out_valid = 1'b0;
        op0_d     = op0_q;
        op1_d     = op1_q;
        lit0_d    = lit0_q;
        lit1_d    = lit1_q;
        ill_d     = ill_q;
        sdst_d    = sdst_q;
        opc_d     = opc_q;
        en64_d    = en64_q;

        case (state_q)
            IDLE: in_ready = 1'b1;
            LIT_WAIT: begin
                lit_ready = 1'b1;
                if (lit_valid) begin
                    if (lit0_q) op0_d = OP_W'(lit_data);
                    if (lit1_q) op1_d = OP_W'(lit_data);
                    lit0_d  = 1'b0;
                    lit1_d  = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready && !in_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        accept = in_valid && in_ready;
        // A new accept overrides whatever the HOLD branch chose, including the IDLE exit.
        if (accept) begin
            op0_d   = dec0.val;
            op1_d   = dec1.val;
            lit0_d  = dec0.lit;
            lit1_d  = dec1.lit;
            ill_d   = dec0.ill | dec1.ill;
            sdst_d  = in_sdst;
            opc_d   = in_opcode;
            en64_d  = in_en_64;
            state_d = (dec0.lit | dec1.lit) ? LIT_WAIT : HOLD;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op0_q   <= '0;
            op1_q   <= '0;
            lit0_q  <= 1'b0;
            lit1_q  <= 1'b0;
            ill_q   <= 1'b0;
            sdst_q  <= '0;
            opc_q   <= '0;
            en64_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            lit0_q  <= lit0_d;
            lit1_q  <= lit1_d;
            ill_q   <= ill_d;
            sdst_q  <= sdst_d;
            opc_q   <= opc_d;
            en64_q  <= en64_d;
        end
    end

    assign out_op0     = op0_q;
    assign out_op1     = op1_q;
    assign out_sdst    = sdst_q;
    assign out_opcode  = opc_q;
    assign out_en_64   = en64_q;
    assign out_illegal = ill_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_scalar_operand_fetch.sv
// Bench for scalar_operand_fetch: vector table, hand-written stall/reset sequences and
// randomized instructions checked against a rule-level operand model.
module tb_scalar_operand_fetch;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ssrc0, in_ssrc1, in_sdst, in_opcode;
    logic        in_en_64;
    logic [7:0]  rf_s0, rf_s1;
    logic [63:0] rf_r0, rf_r1;
    logic        lit_valid;
    logic        lit_ready;
    logic [31:0] lit_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_op0, out_op1;
    logic [7:0]  out_sdst, out_opcode;
    logic        out_en_64, out_illegal;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    scalar_operand_fetch dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ssrc0(in_ssrc0), .in_ssrc1(in_ssrc1), .in_sdst(in_sdst),
        .in_opcode(in_opcode), .in_en_64(in_en_64),
        .rf_s0(rf_s0), .rf_s1(rf_s1), .rf_r0(rf_r0), .rf_r1(rf_r1),
        .lit_valid(lit_valid), .lit_ready(lit_ready), .lit_data(lit_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op0(out_op0), .out_op1(out_op1),
        .out_sdst(out_sdst), .out_opcode(out_opcode), .out_en_64(out_en_64),
        .out_illegal(out_illegal), .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand value from the source-code rules, written as plain arithmetic.
    function automatic logic [63:0] ref_op(input logic [7:0] c, input logic [63:0] rf,
                                           input logic [31:0] lit);
        logic [31:0] fp [8];
        int v;
        fp = '{32'h3F000000, 32'hBF000000, 32'h3F800000, 32'hBF800000,
               32'h40000000, 32'hC0000000, 32'h40800000, 32'hC0800000};
        v = int'(c);
        if (v <= 127 || (v >= 251 && v <= 253)) return rf;
        if (v >= 128 && v <= 192) return 64'(longint'(v - 128));
        if (v >= 193 && v <= 208) return 64'(longint'(192 - v));
        if (v >= 240 && v <= 247) return {32'h0, fp[v - 240]};
        if (v == 255) return {32'h0, lit};
        return 64'h0;
    endfunction

    function automatic logic ref_ill(input logic [7:0] c);
        int v;
        v = int'(c);
        return (v >= 209 && v <= 239) || (v >= 248 && v <= 250) || v == 254;
    endfunction

    // Drives one instruction from IDLE through delivery; all actions on the falling edge.
    task automatic run_instr(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [63:0] r0, input logic [63:0] r1,
                             input logic [31:0] lit, input logic [7:0] dst,
                             input logic [7:0] opc, input logic en, input int lit_dly,
                             input int stall, input logic [63:0] e0, input logic [63:0] e1,
                             input logic eill);
        @(negedge clock);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1; in_ssrc0 = s0; in_ssrc1 = s1; in_sdst = dst; in_opcode = opc;
        in_en_64 = en; rf_r0 = r0; rf_r1 = r1; out_ready = (stall == 0);
        #1;
        chk("rf_s0", rf_s0, s0);
        chk("rf_s1", rf_s1, s1);
        @(negedge clock);
        in_valid = 0; rf_r0 = ~r0; rf_r1 = ~r1;
        if (s0 == 8'hFF || s1 == 8'hFF) begin
            for (int i = 0; i < lit_dly; i++) begin
                chk("lit_ready_wait", lit_ready, 1);
                chk("out_valid_wait", out_valid, 0);
                @(negedge clock);
            end
            chk("lit_ready_take", lit_ready, 1);
            lit_valid = 1; lit_data = lit;
            @(negedge clock);
            lit_data = ~lit;
        end
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_op0", out_op0, e0);
            chk("stall_op1", out_op1, e1);
            @(negedge clock);
        end
        out_ready = 1;
        chk("out_valid", out_valid, 1);
        chk("lit_ready_hold", lit_ready, 0);
        chk("op0", out_op0, e0);
        chk("op1", out_op1, e1);
        chk("illegal", out_illegal, eill);
        chk("sdst", out_sdst, dst);
        chk("opcode", out_opcode, opc);
        chk("en_64", out_en_64, en);
        @(negedge clock);
        lit_valid = 0;
        chk("out_valid_drop", out_valid, 0);
    endtask

    typedef struct {
        logic [7:0]  s0, s1;
        logic [63:0] r0, r1;
        logic [31:0] lit;
        int          lit_dly;
        logic [63:0] e0, e1;
        logic        ill;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{8'h05, 8'h82, 64'h1234, 64'h9, 32'h0, 0, 64'h1234, 64'h2, 1'b0};
        tbl[1]  = '{8'hC1, 8'hF2, 64'h0, 64'h0, 32'h0, 0,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_3F80_0000, 1'b0};
        tbl[2]  = '{8'hFF, 8'hFF, 64'h5, 64'h6, 32'hDEADBEEF, 3,
                    64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{8'h80, 8'hC0, 64'h7, 64'h8, 32'h0, 0, 64'h0, 64'h40, 1'b0};
        tbl[4]  = '{8'hD0, 8'hF7, 64'h0, 64'h0, 32'h0, 0,
                    64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_C080_0000, 1'b0};
        tbl[5]  = '{8'h7F, 8'hE0, 64'hAAAA_5555_AAAA_5555, 64'h3, 32'h0, 0,
                    64'hAAAA_5555_AAAA_5555, 64'h0, 1'b1};
        tbl[6]  = '{8'hFB, 8'hFD, 64'h1111_2222_3333_4444, 64'h8000_0000_0000_0001, 32'h0, 0,
                    64'h1111_2222_3333_4444, 64'h8000_0000_0000_0001, 1'b0};
        tbl[7]  = '{8'hFE, 8'hF0, 64'h1, 64'h1, 32'h0, 0, 64'h0, 64'h3F00_0000, 1'b1};
        tbl[8]  = '{8'hF8, 8'hFF, 64'h1, 64'h1, 32'h12345678, 1, 64'h0, 64'h1234_5678, 1'b1};
        tbl[9]  = '{8'hD1, 8'hEF, 64'h1, 64'h1, 32'h0, 0, 64'h0, 64'h0, 1'b1};
        tbl[10] = '{8'h81, 8'hFA, 64'h1, 64'h1, 32'h0, 0, 64'h1, 64'h0, 1'b1};
        tbl[11] = '{8'h00, 8'hFF, 64'hCAFE, 64'h1, 32'h80000000, 0,
                    64'hCAFE, 64'h0000_0000_8000_0000, 1'b0};

        reset_n = 0; in_valid = 0; in_ssrc0 = 0; in_ssrc1 = 0; in_sdst = 0; in_opcode = 0;
        in_en_64 = 0; rf_r0 = 0; rf_r1 = 0; lit_valid = 0; lit_data = 0; out_ready = 1;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_lit_ready", lit_ready, 0);
        chk("rst_op0", out_op0, 0);
        chk("rst_op1", out_op1, 0);
        chk("rst_sdst", out_sdst, 0);
        chk("rst_opcode", out_opcode, 0);
        chk("rst_en_64", out_en_64, 0);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clock);
        reset_n = 1;

        for (int i = 0; i < 12; i++)
            run_instr(tbl[i].s0, tbl[i].s1, tbl[i].r0, tbl[i].r1, tbl[i].lit,
                      8'(i + 16), 8'(i * 3), i[0], tbl[i].lit_dly, i % 3,
                      tbl[i].e0, tbl[i].e1, tbl[i].ill);

        // Stall with a second instruction waiting, then back-to-back accept.
        @(negedge clock);
        in_valid = 1; in_ssrc0 = 8'h05; in_ssrc1 = 8'h81; rf_r0 = 64'h11; rf_r1 = 64'h0;
        in_sdst = 8'hA1; in_opcode = 8'h01; in_en_64 = 0; out_ready = 0;
        @(negedge clock);
        in_ssrc0 = 8'h10; in_ssrc1 = 8'hC2; rf_r0 = 64'h77; in_sdst = 8'hB2; in_opcode = 8'h02;
        in_en_64 = 1;
        for (int i = 0; i < 5; i++) begin
            chk("b2b_stall_valid", out_valid, 1);
            chk("b2b_stall_in_ready", in_ready, 0);
            chk("b2b_stall_op0", out_op0, 64'h11);
            chk("b2b_stall_sdst", out_sdst, 8'hA1);
            @(negedge clock);
        end
        out_ready = 1;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        @(negedge clock);
        in_valid = 0; rf_r0 = 64'h99;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_op0", out_op0, 64'h77);
        chk("b2b_op1", out_op1, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("b2b_sdst", out_sdst, 8'hB2);
        chk("b2b_en_64", out_en_64, 1);
        @(negedge clock);
        chk("b2b_drop", out_valid, 0);

        // Reset while waiting for a literal.
        in_valid = 1; in_ssrc0 = 8'hFF; in_ssrc1 = 8'h05;
        @(negedge clock);
        in_valid = 0;
        chk("rstlit_lit_ready", lit_ready, 1);
        reset_n = 0;
        #1;
        chk("rstlit_out_valid", out_valid, 0);
        chk("rstlit_lit_ready0", lit_ready, 0);
        @(negedge clock);
        reset_n = 1; lit_valid = 1; lit_data = 32'h5A5A5A5A;
        #1;
        chk("rstlit_in_ready", in_ready, 1);
        chk("rstlit_state", dbg_state, 2'd0);
        @(negedge clock);
        lit_valid = 0;
        chk("rstlit_lit_ignored", out_valid, 0);
        chk("rstlit_op0", out_op0, 0);

        // Randomized instructions against the rule model.
        for (int n = 0; n < 150; n++) begin
            logic [7:0]  s0, s1;
            logic [63:0] r0, r1;
            logic [31:0] lit;
            s0 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            s1 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            r0 = {$urandom, $urandom};
            r1 = {$urandom, $urandom};
            lit = $urandom;
            run_instr(s0, s1, r0, r1, lit, 8'($urandom), 8'($urandom), 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2),
                      ref_op(s0, r0, lit), ref_op(s1, r1, lit), ref_ill(s0) | ref_ill(s1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
